// File: rtl/tof_collect_pkg.sv
// Shared types and helpers for the ToF sample collector.
// Optional feature macro: TOF_COLLECT_TIMESTAMP_EN (adds a 16-bit push timestamp to each sample).
package tof_collect_pkg;
  localparam int NUM_TOF   = 8;
  localparam int TOF_IDX_W = 3;
  localparam int DIST_W    = 16;
  localparam int SIDX_W    = 5;

`ifdef TOF_COLLECT_TIMESTAMP_EN
  localparam int TS_W = 16;
  typedef struct packed {
    logic [TS_W-1:0]      timestamp;
    logic [TOF_IDX_W-1:0] chan;
    logic [SIDX_W-1:0]    sensor_index;
    logic [DIST_W-1:0]    distance;
  } tof_sample_t;
`else
  typedef struct packed {
    logic [TOF_IDX_W-1:0] chan;
    logic [SIDX_W-1:0]    sensor_index;
    logic [DIST_W-1:0]    distance;
  } tof_sample_t;
`endif

  localparam int SAMPLE_W = $bits(tof_sample_t);

  // First enabled index strictly after ptr, wrapping; ptr itself is the last candidate,
  // so a lone enabled sensor keeps the pointer parked on it.
  function automatic logic [TOF_IDX_W-1:0] next_enabled(input logic [TOF_IDX_W-1:0] ptr,
                                                        input logic [NUM_TOF-1:0]   mask);
    logic [TOF_IDX_W-1:0] idx;
    logic                 found;
    next_enabled = ptr;
    found        = 1'b0;
    for (int i = 1; i <= NUM_TOF; i++) begin
      idx = ptr + TOF_IDX_W'(i);
      if (!found && mask[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/tof_sample_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry while not empty.
// A push into a full FIFO is only honoured when a pop happens in the same cycle.
module tof_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];
  assign count  = r_cnt;

  // Storage: no reset needed, contents are invisible while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/tof_sample_collector.sv
// Round-robin drain of the 8-channel ToF front end into a valid/ready sample stream.
// The scan pointer drives the front end's index select directly; the front end clears the
// selected flag each cycle, so a flag seen here is captured (or counted as dropped) exactly once.
// Optional feature macro: TOF_COLLECT_TIMESTAMP_EN (16-bit free-running timestamp per sample).
module tof_sample_collector
  import tof_collect_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_TOF-1:0]            ready_in,
  input  logic [SIDX_W+DIST_W-1:0]      data_in,
  output logic [TOF_IDX_W-1:0]          tof_index,
  input  logic [NUM_TOF-1:0]            enable_mask,
  output logic [SAMPLE_W-1:0]           m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [DROP_W-1:0]             drop_cnt
);
  logic [TOF_IDX_W-1:0] r_ptr;
  logic [DROP_W-1:0]    r_drop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_hit;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_drop;
  tof_sample_t          w_sample;

  // A selected sensor is only captured while its mask bit is still set
  assign w_hit     = ready_in[r_ptr] && enable_mask[r_ptr];
  assign w_pop     = !w_empty && m_ready;
  assign w_accept  = !w_full || w_pop;
  assign w_push    = w_hit && w_accept;
  assign w_drop    = w_hit && !w_accept;
  assign tof_index = r_ptr;
  assign m_valid   = !w_empty;
  assign drop_cnt  = r_drop;

`ifdef TOF_COLLECT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  // Free-running cycle counter, sampled into each pushed sample
  always_ff @(posedge clk) begin
    if (!reset) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end
`endif

  // Pack the sample for the currently selected sensor
  always_comb begin
    w_sample              = '0;
    w_sample.chan         = r_ptr;
    w_sample.sensor_index = data_in[SIDX_W+DIST_W-1:DIST_W];
    w_sample.distance     = data_in[DIST_W-1:0];
`ifdef TOF_COLLECT_TIMESTAMP_EN
    w_sample.timestamp    = r_ts;
`endif
  end

  // Scan pointer: advance to the next enabled sensor, hold when nothing is enabled
  always_ff @(posedge clk) begin
    if (!reset)                 r_ptr <= '0;
    else if (enable_mask != '0) r_ptr <= next_enabled(r_ptr, enable_mask);
  end

  // Saturating count of samples lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!reset)                         r_drop <= '0;
    else if (w_drop && (r_drop != '1))  r_drop <= r_drop + 1'b1;
  end

  tof_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_sample),
    .dout  (m_data),
    .count (fill_level),
    .full  (w_full),
    .empty (w_empty)
  );
endmodule

// File: tb/tb_tof_sample_collector.sv
// Directed bench for tof_sample_collector (FIFO_DEPTH=4) with a small front-end flag model.
module tb_tof_sample_collector;
  import tof_collect_pkg::*;

  localparam int DEPTH = 4;

  logic                        clk;
  logic                        reset;
  logic [NUM_TOF-1:0]          ready_in;
  logic [SIDX_W+DIST_W-1:0]    data_in;
  logic [TOF_IDX_W-1:0]        tof_index;
  logic [NUM_TOF-1:0]          enable_mask;
  logic [SAMPLE_W-1:0]         m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [$clog2(DEPTH):0]      fill_level;
  logic [15:0]                 drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  tof_sample_collector #(.FIFO_DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ready_in    (ready_in),
    .data_in     (data_in),
    .tof_index   (tof_index),
    .enable_mask (enable_mask),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fill_level  (fill_level),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Front-end model: registered flags, set by the bench, cleared when the index selects them
  logic [7:0]  fe_flags = 8'h00;
  logic [7:0]  fe_set;
  logic [20:0] fe_data [8];
  always @(posedge clk) fe_flags <= (fe_flags & ~(8'd1 << tof_index)) | fe_set;
  assign ready_in = fe_flags;
  assign data_in  = fe_data[tof_index];

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  set;
    logic        mrdy;
    logic [2:0]  idx;
    logic        v;
    logic [2:0]  fill;
    logic [15:0] drop;
    logic [23:0] data;
    logic        cd;
  } tv_t;
  tv_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string nm, input logic [2:0] idx, input logic v,
                           input logic [2:0] fill, input logic [15:0] drop);
    chk({nm, ".idx"},  64'(tof_index),  64'(idx));
    chk({nm, ".vld"},  64'(m_valid),    64'(v));
    chk({nm, ".fill"}, 64'(fill_level), 64'(fill));
    chk({nm, ".drop"}, 64'(drop_cnt),   64'(drop));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) fe_data[i] = {5'(i + 16), 16'(16'h1000 + i)};
    fe_data[5] = 21'h0A_1234;

    // Scan only: pointer walks 1..7,0 after reset release
    for (int i = 0; i < 8; i++)
      tv.push_back('{8'hFF, 8'h00, 1'b0, 3'((i + 1) % 8), 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    // Single flag on sensor 5 captured when pointer reaches it, then popped
    tv.push_back('{8'hFF, 8'h20, 1'b0, 3'd1, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd2, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd3, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd6, 1'b1, 3'd1, 16'd0, 24'hAA1234, 1'b1});
    tv.push_back('{8'hFF, 8'h00, 1'b1, 3'd7, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    // Sparse mask alternates 2,5; flags on disabled 0,1 are ignored; empty mask freezes
    tv.push_back('{8'h24, 8'h03, 1'b0, 3'd2, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'h24, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'h24, 8'h00, 1'b0, 3'd2, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'h24, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    // Re-enable all: pending flags 0,1 captured in scan order, then drained
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd6, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd7, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd1, 1'b1, 3'd1, 16'd0, 24'h101000, 1'b1});
    tv.push_back('{8'hFF, 8'h00, 1'b0, 3'd2, 1'b1, 3'd2, 16'd0, 24'h101000, 1'b1});
    tv.push_back('{8'hFF, 8'h00, 1'b1, 3'd3, 1'b1, 3'd1, 16'd0, 24'h311001, 1'b1});
    tv.push_back('{8'hFF, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0, 16'd0, 24'h0, 1'b0});

    // Reset
    reset = 1'b0; enable_mask = 8'hFF; fe_set = 8'h00; m_ready = 1'b0;
    step(); step();
    chk_state("reset", 3'd0, 1'b0, 3'd0, 16'd0);
    reset = 1'b1;

    foreach (tv[k]) begin
      enable_mask = tv[k].mask;
      fe_set      = tv[k].set;
      m_ready     = tv[k].mrdy;
      step();
      fe_set = 8'h00;
      chk_state($sformatf("vec%0d", k), tv[k].idx, tv[k].v, tv[k].fill, tv[k].drop);
      if (tv[k].cd) chk($sformatf("vec%0d.data", k), 64'(m_data[23:0]), 64'(tv[k].data));
    end

    // Overflow: all flags pending out of reset, FIFO of 4, no consumer
    m_ready = 1'b0; enable_mask = 8'hFF; reset = 1'b0;
    step();
    chk_state("rst2", 3'd0, 1'b0, 3'd0, 16'd0);
    fe_set = 8'hFF;
    step();
    fe_set = 8'h00; reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_state("ovf.half", 3'd4, 1'b1, 3'd4, 16'd0);
    for (int i = 0; i < 4; i++) step();
    chk_state("ovf.sweep", 3'd0, 1'b1, 3'd4, 16'd4);
    chk("ovf.head0", 64'(m_data[23:0]), 64'h101000);
    m_ready = 1'b1;
    step(); chk("drain.ch1", 64'(m_data[23:0]), 64'h311001); chk("drain.f3", 64'(fill_level), 64'd3);
    step(); chk("drain.ch2", 64'(m_data[23:0]), 64'h521002); chk("drain.f2", 64'(fill_level), 64'd2);
    step(); chk("drain.ch3", 64'(m_data[23:0]), 64'h731003); chk("drain.f1", 64'(fill_level), 64'd1);
    step();
    chk_state("drain.end", 3'd4, 1'b0, 3'd0, 16'd4);

    // Full FIFO hit with consumer ready: push and pop on the same edge
    m_ready = 1'b0; fe_set = 8'hE5;
    step();
    fe_set = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk_state("full", 3'd2, 1'b1, 3'd4, 16'd4);
    chk("full.head", 64'(m_data[23:0]), 64'hAA1234);
    m_ready = 1'b1;
    step();
    chk_state("pushpop", 3'd3, 1'b1, 3'd4, 16'd4);
    chk("pushpop.head", 64'(m_data[23:0]), 64'hD61006);
    step();
    chk_state("fill3", 3'd4, 1'b1, 3'd3, 16'd4);
    chk("fill3.head", 64'(m_data[23:0]), 64'hF71007);

    // Reset mid-stream discards everything; capture resumes cleanly afterwards
    m_ready = 1'b0; reset = 1'b0; fe_set = 8'h02;
    step();
    chk_state("midrst", 3'd0, 1'b0, 3'd0, 16'd0);
    reset = 1'b1; fe_set = 8'h00;
    step(); step();
    chk_state("postrst", 3'd2, 1'b1, 3'd1, 16'd0);
    chk("postrst.data", 64'(m_data[23:0]), 64'h311001);
`ifdef TOF_COLLECT_TIMESTAMP_EN
    chk("postrst.ts", 64'(m_data[39:24]), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
